// File: rtl/vga_capture.sv
// vga_capture: recovers VGA timing from hsync/vsync and writes captured green-MSB lines to VRAM
//   dclk       pixel clock (only clock)
//   rst        asynchronous active-high reset
//   hsync      horizontal sync, active low
//   vsync      vertical sync, active low
//   grn        green pixel value; bit 2 is captured
//   wr_en      one-cycle VRAM line write strobe
//   wr_addr    VRAM line address (raw line count)
//   wr_line    captured line, bit k = active column k
//   frame_done pulses with the write of the last active line
//   sync_err   one-cycle pulse on a timing violation
//   locked     high while the timing is locked
module vga_capture #(
  parameter int HTOTAL      = 800,
  parameter int VTOTAL      = 521,
  parameter int H_ACT_START = 144,
  parameter int H_ACT_END   = 784,
  parameter int V_ACT_START = 31,
  parameter int V_ACT_END   = 511
) (
  input  logic                                 dclk,
  input  logic                                 rst,
  input  logic                                 hsync,
  input  logic                                 vsync,
  input  logic [2:0]                           grn,
  output logic                                 wr_en,
  output logic [8:0]                           wr_addr,
  output logic [H_ACT_END-H_ACT_START-1:0]     wr_line,
  output logic                                 frame_done,
  output logic                                 sync_err,
  output logic                                 locked
);
  localparam int LW = H_ACT_END - H_ACT_START;
  typedef enum logic {SEARCH, LOCKED} state_t;
  state_t state, state_nxt;
  logic hsync_d, vsync_d, hfall, vfall, active, last_col, err_nxt;
  logic [9:0] hcnt, vcnt, hpos;
  logic [LW-1:0] line_q, line_nxt;
  assign hfall = hsync_d & ~hsync;
  assign vfall = vsync_d & ~vsync;
  assign hpos = hfall ? 10'd0 : hcnt;
  assign locked = state == LOCKED;
  assign active = locked && hpos >= 10'(H_ACT_START) && hpos < 10'(H_ACT_END)
               && vcnt >= 10'(V_ACT_START) && vcnt < 10'(V_ACT_END);
  assign last_col = active && hpos == 10'(H_ACT_END - 1);
  // vfall always (re)locks; a bad line length only breaks lock when no vfall arrives alongside it
  always_comb begin
    state_nxt = state;
    err_nxt = 1'b0;
    if (vfall) begin
      state_nxt = LOCKED;
      err_nxt = locked && vcnt != 10'(VTOTAL - 1);
    end else if (locked && hfall && hcnt != 10'(HTOTAL)) begin
      state_nxt = SEARCH;
      err_nxt = 1'b1;
    end
  end
  // line_nxt already holds the sample taken this cycle, so the write at the last column includes it
  always_comb begin
    line_nxt = line_q;
    for (int k = 0; k < LW; k++)
      if (active && hpos == 10'(k + H_ACT_START)) line_nxt[k] = grn[2];
  end
  always_ff @(posedge dclk or posedge rst)
    if (rst) state <= SEARCH;
    else state <= state_nxt;
  always_ff @(posedge dclk or posedge rst)
    if (rst) begin
      hsync_d <= 1'b1;
      vsync_d <= 1'b1;
      hcnt <= '0;
      vcnt <= '0;
      line_q <= '0;
      wr_en <= 1'b0;
      frame_done <= 1'b0;
      sync_err <= 1'b0;
      wr_addr <= '0;
      wr_line <= '0;
    end else begin
      hsync_d <= hsync;
      vsync_d <= vsync;
      hcnt <= hpos == 10'd1023 ? hpos : hpos + 10'd1;
      vcnt <= vfall ? 10'd0 : (hfall && vcnt != 10'd1023) ? vcnt + 10'd1 : vcnt;
      line_q <= line_nxt;
      wr_en <= last_col;
      frame_done <= last_col && vcnt == 10'(V_ACT_END - 1);
      sync_err <= err_nxt;
      if (last_col) begin
        wr_addr <= vcnt[8:0];
        wr_line <= line_nxt;
      end
    end
endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: frame-level scoreboard bench for vga_capture on scaled-down timing
module tb_vga_capture;
  localparam int HT = 100, VT = 30, HAS = 20, HAE = 84, VAS = 4, VAE = 26;
  localparam int LW = HAE - HAS, HSW = 12, VSW = 2, SPARSE_V = 10;
  typedef logic [63:0] w_t;
  typedef logic [$clog2(LW)-1:0] idx_t;
  typedef struct {
    logic [8:0]    addr;
    logic [LW-1:0] line;
    longint        edge_n;
  } wr_t;
  typedef struct {
    int   mode, nl, sl, slen, rl, rh, ewr, eerr, efd;
    logic elock;
  } vec_t;
  logic dclk = 1'b0, rst = 1'b1, hsync = 1'b1, vsync = 1'b1;
  logic [2:0] grn = 3'd0;
  logic wr_en, frame_done, sync_err, locked;
  logic [8:0] wr_addr;
  logic [LW-1:0] wr_line;
  wr_t sb[$];
  wr_t mon_e;
  vec_t tv[9];
  int n_chk = 0, n_fail = 0, n_wr = 0, n_err = 0, n_fd = 0, cur_mode = 0;
  longint cyc = 0;
  logic exp_locked = 1'b0;
  logic [8:0] last_addr = '0;
  logic [LW-1:0] last_line = '0, exp_line = '0;

  vga_capture #(.HTOTAL(HT), .VTOTAL(VT), .H_ACT_START(HAS), .H_ACT_END(HAE),
                .V_ACT_START(VAS), .V_ACT_END(VAE)) dut (
    .dclk(dclk), .rst(rst), .hsync(hsync), .vsync(vsync), .grn(grn),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_line(wr_line),
    .frame_done(frame_done), .sync_err(sync_err), .locked(locked)
  );

  always #20 dclk = ~dclk;
  always @(posedge dclk) cyc <= cyc + 1;

  task automatic chk(input string name, input w_t act, input w_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge dclk) if (!rst) begin
    if (sync_err) n_err++;
    if (frame_done) n_fd++;
    if (wr_en) begin
      n_wr++;
      if (sb.size() == 0) chk("unexpected_wr", w_t'(wr_en), 64'd0);
      else begin
        mon_e = sb.pop_front();
        chk("wr_addr", w_t'(wr_addr), w_t'(mon_e.addr));
        chk("wr_line", w_t'(wr_line), w_t'(mon_e.line));
        chk("wr_timing", w_t'(cyc), w_t'(mon_e.edge_n));
        chk("frame_done", w_t'(frame_done), w_t'(mon_e.addr == 9'(VAE - 1)));
        if (cur_mode == 1 && mon_e.addr == 9'(SPARSE_V))
          chk("sparse_line", w_t'(wr_line), {1'b1, 62'd0, 1'b1});
        last_addr = mon_e.addr;
        last_line = mon_e.line;
      end
    end else if (frame_done) chk("frame_done_alone", w_t'(frame_done), 64'd0);
  end

  task automatic chk_reset_state();
    chk("rst_wr_en", w_t'(wr_en), 64'd0);
    chk("rst_frame_done", w_t'(frame_done), 64'd0);
    chk("rst_sync_err", w_t'(sync_err), 64'd0);
    chk("rst_locked", w_t'(locked), 64'd0);
    chk("rst_wr_addr", w_t'(wr_addr), 64'd0);
    chk("rst_wr_line", w_t'(wr_line), 64'd0);
    chk("rst_hcnt", w_t'(dut.hcnt), 64'd0);
    chk("rst_vcnt", w_t'(dut.vcnt), 64'd0);
    chk("rst_line_q", w_t'(dut.line_q), 64'd0);
    chk("rst_syncs_d", w_t'({dut.hsync_d, dut.vsync_d}), 64'd3);
  endtask

  // Drives one frame like the companion transmitter: hsync low for h<HSW, vsync low for v<VSW.
  task automatic drive_frame(input vec_t t);
    logic [2:0] g;
    int len;
    for (int v = 0; v < t.nl; v++) begin
      len = (v == t.sl) ? t.slen : HT;
      for (int h = 0; h < len; h++) begin
        rst = 1'b0;
        g = t.mode == 0 ? 3'd7
          : t.mode == 1 ? ((v == SPARSE_V && (h == HAS || h == HAE - 1)) ? 3'd7 : 3'd0)
          : 3'($urandom_range(0, 7));
        hsync = h >= HSW;
        vsync = v >= VSW;
        grn = g;
        if (v == 0 && h == 0) exp_locked = 1'b1;
        if (h >= HAS && h < HAE) exp_line[idx_t'(h - HAS)] = g[2];
        if (v == t.rl && h == t.rh) begin
          rst = 1'b1;
          exp_locked = 1'b0;
          last_addr = '0;
          last_line = '0;
          #1;
          chk_reset_state();
        end
        if (exp_locked && h == HAE - 1 && v >= VAS && v < VAE)
          sb.push_back('{addr: 9'(v), line: exp_line, edge_n: cyc + 1});
        @(posedge dclk);
        #1;
      end
      if (v == t.sl) exp_locked = 1'b0;
    end
    @(negedge dclk);
    #1;
  endtask

  initial begin
    int wr0, err0, fd0;
    tv[0] = '{0, VT, -1, 0, -1, 0, VAE - VAS, 0, 1, 1'b1};
    tv[1] = '{0, VT, -1, 0, -1, 0, VAE - VAS, 0, 1, 1'b1};
    tv[2] = '{1, VT, -1, 0, -1, 0, VAE - VAS, 0, 1, 1'b1};
    tv[3] = '{2, VT, 15, 70, -1, 0, 11, 1, 0, 1'b0};
    tv[4] = '{2, VT, -1, 0, -1, 0, VAE - VAS, 0, 1, 1'b1};
    tv[5] = '{0, VT - 2, -1, 0, -1, 0, VAE - VAS, 0, 1, 1'b1};
    tv[6] = '{2, VT, -1, 0, -1, 0, VAE - VAS, 1, 1, 1'b1};
    tv[7] = '{2, VT, -1, 0, 12, 50, 8, 0, 0, 1'b0};
    tv[8] = '{2, VT, -1, 0, -1, 0, VAE - VAS, 0, 1, 1'b1};
    repeat (3) @(posedge dclk);
    #1;
    chk_reset_state();
    rst = 1'b0;
    wr0 = n_wr;
    err0 = n_err;
    repeat (2000) @(posedge dclk);
    #1;
    chk("sat_hcnt", w_t'(dut.hcnt), 64'd1023);
    chk("sat_no_err", w_t'(n_err - err0), 64'd0);
    chk("sat_no_wr", w_t'(n_wr - wr0), 64'd0);
    chk("sat_locked", w_t'(locked), 64'd0);
    for (int i = 0; i < 9; i++) begin
      wr0 = n_wr;
      err0 = n_err;
      fd0 = n_fd;
      cur_mode = tv[i].mode;
      drive_frame(tv[i]);
      chk($sformatf("f%0d_writes", i), w_t'(n_wr - wr0), w_t'(tv[i].ewr));
      chk($sformatf("f%0d_sync_errs", i), w_t'(n_err - err0), w_t'(tv[i].eerr));
      chk($sformatf("f%0d_frame_done", i), w_t'(n_fd - fd0), w_t'(tv[i].efd));
      chk($sformatf("f%0d_locked", i), w_t'(locked), w_t'(tv[i].elock));
      chk($sformatf("f%0d_hold_addr", i), w_t'(wr_addr), w_t'(last_addr));
      chk($sformatf("f%0d_hold_line", i), w_t'(wr_line), w_t'(last_line));
    end
    chk("sb_empty", w_t'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
